bounce_updater_n: RTL and testbench
===================================

// Module: bounce_updater_n
// PURPOSE
//   Per-frame game-state engine for the colour-bounce game, generalised to N_PLAT platforms.
//   On each step pulse from the controller it:
//     - checks the key/platform/colour match,
//     - recolours platforms and ball from an internal LFSR on a hit,
//     - moves the ball up or down, and updates score and gameover.
//   Sits between the game controller FSM and the VGA draw/erase datapath.
// PARAMETERS
//   N_PLAT     4       number of platforms and keys (2..8)
//   POS_W      8       ball/platform vertical position width
//   COL_W      3       colour width per object
//   BALL_H     4       hit window: plat_pos in [ball_pos, ball_pos+BALL_H]
//   BOUNCE_LEN 50      frames the ball rises after a hit (fits 6 bits)
//   FLOOR_Y    160     ball_pos >= FLOOR_Y means game over
//   START_Y    0       ball_pos after reset/restart
//   LFSR_SEED  16'hACE1  non-zero LFSR seed
// PORTS
//   clk          in   1               system clock
//   resetn       in   1               async active-low reset
//   step         in   1               1-cycle pulse: advance one frame
//   restart      in   1               1-cycle pulse: leave OVER, new game
//   keys         in   N_PLAT          active-low keys, bit k <-> platform k
//   plat_pos     in   N_PLAT*POS_W    platform k position at [k*POS_W +: POS_W]
//   ball_pos     out  POS_W           current ball position
//   prev_ball    out  POS_W           ball position before last move (for erase)
//   ball_color   out  COL_W           ball colour
//   plat_colors  out  N_PLAT*COL_W    platform k colour at [k*COL_W +: COL_W]
//   score        out  16              game score, saturates at 16'hFFFF
//   gameover     out  1               sticky until restart
//   done         out  1               1-cycle pulse: frame update visible
//   busy         out  1               high in CHECK/MOVE
// BEHAVIOUR
// - Reset values:
//     - ball_pos = prev_ball = START_Y; score = 0; gameover = 0; done = 0; up_cnt = 0.
//     - State IDLE; LFSR = LFSR_SEED.
//     - plat_colors[k] = k+1 (mod 2^COL_W); ball_color = plat_colors[0].
// - LFSR: 16-bit Galois, taps 16,14,13,11; advances every clk in every state; never zero.
// - FSM:
//     - IDLE --step--> CHECK --> MOVE --> IDLE
//     - MOVE --(new ball_pos >= FLOOR_Y)--> OVER
//     - OVER --restart--> IDLE
//     - step is ignored outside IDLE; restart is ignored outside OVER.
// - Latency: step sampled at edge E; touch registered at E+1; outputs updated at E+2; done=1 for the cycle after E+2.
// - CHECK:
//     - touch=1 iff up_cnt==0, keys has exactly one bit low (index k), ball_color==plat_colors[k], and ball_pos <= plat_pos[k] <= ball_pos+BALL_H.
//     - The sum ball_pos+BALL_H is computed at POS_W+1 bits (no wrap).
//     - Zero or multiple keys low -> touch=0.
// - MOVE:
//     - prev_ball <= ball_pos.
//     - On touch:
//         - plat_colors[k] <= LFSR slice k.
//         - ball_color <= new plat_colors[LFSR[15:13] % N_PLAT] (ball always matches some platform).
//         - up_cnt <= BOUNCE_LEN; score += 1 (saturating).
//     - Ball motion (the touch-frame move already uses the new up_cnt):
//         - up_cnt==0: ball_pos+1.
//         - otherwise: ball_pos-1 and up_cnt-1.
//         - If ball_pos==0 while rising: ball stays 0 and up_cnt <= 0.
// - Game over:
//     - If the new ball_pos >= FLOOR_Y: gameover <= 1; enter OVER.
//     - score is held in OVER (not cleared) for display.
// - restart in OVER:
//     - ball_pos = prev_ball = START_Y; score = 0; up_cnt = 0; gameover = 0.
//     - Colours are left as-is.
// - resetn low mid-frame: all state returns to reset values immediately; no done pulse is emitted.
// CONFIGURATION
//   BOUNCE_COMBO_EN defined:
//     - Internal 2-bit streak; each touch adds streak+1 to score (1,2,3,4, capped at 4), then streak++ (saturating at 3).
//     - A miss (single key low, touch=0, up_cnt==0) clears streak; restart clears streak.
//   BOUNCE_COMBO_EN undefined: every touch adds exactly 1; no streak logic.
// TESTING
// - Fall: reset, issue 10 steps with keys=4'hF -> ball_pos=10, prev_ball=9, score=0, 10 done pulses, each 3 cycles after its step.
// - Hit: ball_pos=20, ball_color==plat_colors[2], plat_pos[2]=22, keys=4'b1011, step -> score=1, ball_pos=19, up_cnt=49, plat_colors changed.
// - Miss: same setup but keys=4'b1101 (wrong colour) or keys=4'b0011 (two keys) -> score unchanged, ball_pos=21.
// - Over: ball_pos=159, falling, step -> gameover=1, ball_pos=160, score held; further steps ignored; restart -> ball_pos=0, score=0, gameover=0.
// - Protocol: step asserted during CHECK/MOVE is ignored (one done only); resetn pulse during CHECK -> no done, reset values.
// - Combo (BOUNCE_COMBO_EN): three consecutive hits -> score 1,3,6; then a miss followed by a hit -> +1.

Source files
------------

// File: rtl/bounce_updater_n.sv
// bounce_updater_n: per-frame game-state engine for the colour-bounce game with N_PLAT platforms.
// Optional feature macro BOUNCE_COMBO_EN: consecutive hits score 1,2,3,4 via a 2-bit streak.
module bounce_updater_n #(
    parameter int          N_PLAT     = 4,
    parameter int          POS_W      = 8,
    parameter int          COL_W      = 3,
    parameter int          BALL_H     = 4,
    parameter int          BOUNCE_LEN = 50,
    parameter int          FLOOR_Y    = 160,
    parameter int          START_Y    = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      step,
    input  logic                      restart,
    input  logic [N_PLAT-1:0]         keys,
    input  logic [N_PLAT*POS_W-1:0]   plat_pos,
    output logic [POS_W-1:0]          ball_pos,
    output logic [POS_W-1:0]          prev_ball,
    output logic [COL_W-1:0]          ball_color,
    output logic [N_PLAT*COL_W-1:0]   plat_colors,
    output logic [15:0]               score,
    output logic                      gameover,
    output logic                      done,
    output logic                      busy
);
    localparam int KW   = (N_PLAT > 1) ? $clog2(N_PLAT) : 1;
    localparam int UP_W = $clog2(BOUNCE_LEN + 1);
    localparam int CW   = N_PLAT * COL_W;

    localparam logic [UP_W-1:0]  UP_LOAD   = UP_W'(BOUNCE_LEN);
    localparam logic [POS_W-1:0] START_POS = POS_W'(START_Y);
    localparam logic [POS_W:0]   FLOOR_POS = (POS_W + 1)'(FLOOR_Y);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_MOVE,
        S_OVER
    } state_t;

    function automatic logic [CW-1:0] reset_colors();
        logic [CW-1:0] c;
        c = '0;
        for (int k = 0; k < N_PLAT; k++) begin
            c[k*COL_W +: COL_W] = COL_W'(k + 1);
        end
        return c;
    endfunction

    state_t            state_reg;
    logic [15:0]       lfsr_reg;
    logic [15:0]       lfsr_next;
    logic [POS_W-1:0]  ball_pos_reg;
    logic [POS_W-1:0]  prev_ball_reg;
    logic [COL_W-1:0]  ball_color_reg;
    logic [CW-1:0]     plat_colors_reg;
    logic [15:0]       score_reg;
    logic              gameover_reg;
    logic              done_reg;
    logic [UP_W-1:0]   up_cnt_reg;
    logic              touch_reg;

    // Check-phase signals
    logic [N_PLAT-1:0] key_low;
    logic              one_low;
    logic [KW-1:0]     key_idx;
    logic [POS_W-1:0]  key_plat;
    logic [COL_W-1:0]  key_col;
    logic [POS_W:0]    win_hi;
    logic              in_window;
    logic              touch_c;

    // Move-phase signals
    logic [CW-1:0]     new_colors;
    logic [KW-1:0]     sel_idx;
    logic [COL_W-1:0]  new_ball_color;
    logic [UP_W-1:0]   up_eff;
    logic [UP_W-1:0]   up_next;
    logic [POS_W-1:0]  ball_next;
    logic              hit_floor;
    logic [15:0]       score_inc;
    logic [16:0]       score_sum;
    logic [15:0]       score_next;

`ifdef BOUNCE_COMBO_EN
    logic [1:0]        streak_reg;
    logic              miss_reg;
    logic              miss_c;
`endif

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1; a non-zero seed never reaches zero
    assign lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign key_low = ~keys;
    assign one_low = $onehot(key_low);

    always_comb begin
        key_idx = '0;
        for (int k = 0; k < N_PLAT; k++) begin
            if (key_low[k]) begin
                key_idx = KW'(k);
            end
        end
    end

    assign key_plat  = plat_pos[key_idx*POS_W +: POS_W];
    assign key_col   = plat_colors_reg[key_idx*COL_W +: COL_W];
    assign win_hi    = {1'b0, ball_pos_reg} + (POS_W + 1)'(BALL_H);
    assign in_window = (key_plat >= ball_pos_reg) && ({1'b0, key_plat} <= win_hi);
    assign touch_c   = (up_cnt_reg == '0) && one_low && (key_col == ball_color_reg) && in_window;

`ifdef BOUNCE_COMBO_EN
    assign miss_c    = (up_cnt_reg == '0) && one_low && !touch_c;
`endif

    // Slices wrap around the 16-bit LFSR when N_PLAT*COL_W exceeds 16
    for (genvar gi = 0; gi < CW; gi++) begin : g_recolour
        assign new_colors[gi] = lfsr_reg[gi % 16];
    end

    assign sel_idx        = KW'(32'(lfsr_reg[15:13]) % N_PLAT);
    assign new_ball_color = new_colors[sel_idx*COL_W +: COL_W];

    // The touch frame already moves with the freshly loaded bounce counter
    always_comb begin
        up_eff    = touch_reg ? UP_LOAD : up_cnt_reg;
        ball_next = ball_pos_reg;
        up_next   = up_eff;
        if (up_eff == '0) begin
            ball_next = ball_pos_reg + POS_W'(1);
        end else if (ball_pos_reg == '0) begin
            up_next = '0;
        end else begin
            ball_next = ball_pos_reg - POS_W'(1);
            up_next   = up_eff - UP_W'(1);
        end
    end

    assign hit_floor = ({1'b0, ball_next} >= FLOOR_POS);

`ifdef BOUNCE_COMBO_EN
    assign score_inc = {14'd0, streak_reg} + 16'd1;
`else
    assign score_inc = 16'd1;
`endif
    assign score_sum  = {1'b0, score_reg} + {1'b0, score_inc};
    assign score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg       <= S_IDLE;
            ball_pos_reg    <= START_POS;
            prev_ball_reg   <= START_POS;
            ball_color_reg  <= COL_W'(1);
            plat_colors_reg <= reset_colors();
            score_reg       <= '0;
            gameover_reg    <= 1'b0;
            done_reg        <= 1'b0;
            up_cnt_reg      <= '0;
            touch_reg       <= 1'b0;
`ifdef BOUNCE_COMBO_EN
            streak_reg      <= '0;
            miss_reg        <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (step) begin
                        state_reg <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    touch_reg <= touch_c;
`ifdef BOUNCE_COMBO_EN
                    miss_reg  <= miss_c;
`endif
                    state_reg <= S_MOVE;
                end
                S_MOVE: begin
                    prev_ball_reg <= ball_pos_reg;
                    ball_pos_reg  <= ball_next;
                    up_cnt_reg    <= up_next;
                    done_reg      <= 1'b1;
                    if (touch_reg) begin
                        plat_colors_reg <= new_colors;
                        ball_color_reg  <= new_ball_color;
                        score_reg       <= score_next;
                    end
`ifdef BOUNCE_COMBO_EN
                    if (touch_reg) begin
                        streak_reg <= (streak_reg == 2'd3) ? 2'd3 : streak_reg + 2'd1;
                    end else if (miss_reg) begin
                        streak_reg <= '0;
                    end
`endif
                    if (hit_floor) begin
                        gameover_reg <= 1'b1;
                        state_reg    <= S_OVER;
                    end else begin
                        state_reg    <= S_IDLE;
                    end
                end
                S_OVER: begin
                    // Colours survive a restart; score is kept on display until then
                    if (restart) begin
                        ball_pos_reg  <= START_POS;
                        prev_ball_reg <= START_POS;
                        score_reg     <= '0;
                        up_cnt_reg    <= '0;
                        gameover_reg  <= 1'b0;
`ifdef BOUNCE_COMBO_EN
                        streak_reg    <= '0;
`endif
                        state_reg     <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign ball_pos    = ball_pos_reg;
    assign prev_ball   = prev_ball_reg;
    assign ball_color  = ball_color_reg;
    assign plat_colors = plat_colors_reg;
    assign score       = score_reg;
    assign gameover    = gameover_reg;
    assign done        = done_reg;
    assign busy        = (state_reg == S_CHECK) || (state_reg == S_MOVE);

endmodule

// File: tb/tb_bounce_updater_n.sv
// Self-checking bench for bounce_updater_n: table of check-phase vectors plus hand sequences,
// with a reference model pushing expected frame results into a scoreboard queue.
module tb_bounce_updater_n;
    localparam int N  = 4;
    localparam int PW = 8;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            resetn;
    logic            step;
    logic            restart;
    logic [N-1:0]    keys;
    logic [N*PW-1:0] plat_pos;
    logic [PW-1:0]   ball_pos;
    logic [PW-1:0]   prev_ball;
    logic [CW-1:0]   ball_color;
    logic [N*CW-1:0] plat_colors;
    logic [15:0]     score;
    logic            gameover;
    logic            done;
    logic            busy;

    bounce_updater_n dut (
        .clk        (clk),
        .resetn     (resetn),
        .step       (step),
        .restart    (restart),
        .keys       (keys),
        .plat_pos   (plat_pos),
        .ball_pos   (ball_pos),
        .prev_ball  (prev_ball),
        .ball_color (ball_color),
        .plat_colors(plat_colors),
        .score      (score),
        .gameover   (gameover),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [PW-1:0]   ball;
        logic [PW-1:0]   prev;
        logic [CW-1:0]   bcol;
        logic [N*CW-1:0] pcol;
        logic [15:0]     score;
        logic            over;
    } exp_t;

    typedef struct {
        string        name;
        logic [N-1:0] keys;
        int           off;
        bit           hit;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    // Reference model state
    logic [15:0]     tb_lfsr;
    logic [PW-1:0]   m_ball;
    logic [PW-1:0]   m_prev;
    logic [CW-1:0]   m_bcol;
    logic [N*CW-1:0] m_pcol;
    logic [15:0]     m_score;
    int              m_up;
    bit              m_over;
    int              m_streak;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        logic [15:0] r;
        r = {1'b0, v[15:1]};
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) tb_lfsr <= 16'hACE1;
        else         tb_lfsr <= lfsr_adv(tb_lfsr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_ball   = 8'd0;
        m_prev   = 8'd0;
        m_bcol   = 3'd1;
        m_pcol   = {3'd4, 3'd3, 3'd2, 3'd1};
        m_score  = 16'd0;
        m_up     = 0;
        m_over   = 1'b0;
        m_streak = 0;
    endtask

    // Called on the cycle the step is driven; the MOVE edge sees the LFSR two advances later
    task automatic model_step(input logic [N-1:0] k, input bit hit, input string name);
        logic [15:0] l;
        logic [N-1:0] low;
        int sel;
        int inc;
        int sum;
        exp_t e;
        l   = lfsr_adv(lfsr_adv(tb_lfsr));
        low = ~k;
        if (hit) begin
            for (int i = 0; i < N*CW; i++) m_pcol[i] = l[i % 16];
            sel    = int'(l[15:13]) % N;
            m_bcol = m_pcol[sel*CW +: CW];
            m_up   = 50;
            inc    = 1;
`ifdef BOUNCE_COMBO_EN
            inc = m_streak + 1;
            if (m_streak < 3) m_streak++;
`endif
            sum     = int'(m_score) + inc;
            m_score = (sum > 65535) ? 16'hFFFF : 16'(sum);
        end else if ($countones(low) == 1 && m_up == 0) begin
            m_streak = 0;
        end
        m_prev = m_ball;
        if (m_up == 0) begin
            m_ball = m_ball + 8'd1;
        end else if (m_ball == 8'd0) begin
            m_up = 0;
        end else begin
            m_ball = m_ball - 8'd1;
            m_up--;
        end
        if (m_ball >= 8'd160) m_over = 1'b1;
        e.name  = name;
        e.ball  = m_ball;
        e.prev  = m_prev;
        e.bcol  = m_bcol;
        e.pcol  = m_pcol;
        e.score = m_score;
        e.over  = m_over;
        sb_q.push_back(e);
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding frame
    always @(posedge clk) begin
        #1;
        if (done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'(done_cnt), 32'(0));
            end else begin
                mon_e = sb_q.pop_front();
                chk({mon_e.name, " ball_pos"},    32'(ball_pos),    32'(mon_e.ball));
                chk({mon_e.name, " prev_ball"},   32'(prev_ball),   32'(mon_e.prev));
                chk({mon_e.name, " ball_color"},  32'(ball_color),  32'(mon_e.bcol));
                chk({mon_e.name, " plat_colors"}, 32'(plat_colors), 32'(mon_e.pcol));
                chk({mon_e.name, " score"},       32'(score),       32'(mon_e.score));
                chk({mon_e.name, " gameover"},    32'(gameover),    32'(mon_e.over));
            end
        end
    end

    task automatic do_step(input logic [N-1:0] k, input logic [PW-1:0] pp, input bit hit,
                           input string name);
        int lat;
        @(negedge clk);
        keys     = k;
        plat_pos = {N{pp}};
        model_step(k, hit, name);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        lat  = 1;
        while (lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
        chk({name, " latency"}, 32'(lat), 32'(3));
        @(posedge clk);
        #1;
        chk({name, " done_width"}, 32'(done), 32'(0));
    endtask

    vec_t tbl[7];
    int   km;
    int   guard;
    int   cnt0;
    logic [PW-1:0] pp;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Platform 0 is the only colour match for the ball until the first hit
        tbl[0] = '{"no_key",      4'b1111,  2, 1'b0};
        tbl[1] = '{"wrong_color", 4'b1101,  2, 1'b0};
        tbl[2] = '{"two_keys",    4'b1100,  2, 1'b0};
        tbl[3] = '{"above_win",   4'b1110,  5, 1'b0};
        tbl[4] = '{"below_win",   4'b1110, -1, 1'b0};
        tbl[5] = '{"hit_top",     4'b1110,  4, 1'b1};
        tbl[6] = '{"rising",      4'b1110,  0, 1'b0};

        resetn   = 1'b0;
        step     = 1'b0;
        restart  = 1'b0;
        keys     = 4'hF;
        plat_pos = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        chk("rst ball_pos",    32'(ball_pos),    32'(0));
        chk("rst prev_ball",   32'(prev_ball),   32'(0));
        chk("rst score",       32'(score),       32'(0));
        chk("rst gameover",    32'(gameover),    32'(0));
        chk("rst done",        32'(done),        32'(0));
        chk("rst busy",        32'(busy),        32'(0));
        chk("rst plat_colors", 32'(plat_colors), 32'h8D1);
        chk("rst ball_color",  32'(ball_color),  32'(1));

        for (int i = 0; i < 10; i++) do_step(4'hF, 8'd200, 1'b0, "fall");
        chk("fall ball_pos",  32'(ball_pos),  32'(10));
        chk("fall prev_ball", 32'(prev_ball), 32'(9));
        chk("fall score",     32'(score),     32'(0));
        chk("fall done_cnt",  32'(done_cnt),  32'(10));

        for (int i = 0; i < 10; i++) do_step(4'hF, 8'd200, 1'b0, "fall");
        chk("fall20 ball_pos", 32'(ball_pos), 32'(20));

        for (int i = 0; i < 7; i++) begin
            pp = 8'(int'(m_ball) + tbl[i].off);
            do_step(tbl[i].keys, pp, tbl[i].hit, tbl[i].name);
            if (tbl[i].hit) begin
                chk("hit score",    32'(score),    32'(1));
                chk("hit ball_pos", 32'(ball_pos), 32'(24));
                chk("hit recolour", 32'(plat_colors != 12'h8D1), 32'(1));
            end
        end

        // Rise until the bounce counter clears, including the clamp at the top
        guard = 0;
        while (m_up != 0 && guard < 80) begin
            do_step(4'hF, 8'd200, 1'b0, "rise");
            guard++;
        end
        chk("ceiling ball_pos", 32'(ball_pos), 32'(0));
        chk("ceiling prev_ball", 32'(prev_ball), 32'(0));

        do_step(4'hF, 8'd200, 1'b0, "fall");
        km = 0;
        for (int j = N - 1; j >= 0; j--) if (m_pcol[j*CW +: CW] == m_bcol) km = j;
        do_step(~(4'b0001 << km), m_ball, 1'b1, "hit_bottom");

        guard = 0;
        while (m_up != 0 && guard < 80) begin
            do_step(4'hF, 8'd200, 1'b0, "rise");
            guard++;
        end

        guard = 0;
        while (!m_over && guard < 300) begin
            do_step(4'hF, 8'd200, 1'b0, "to_floor");
            guard++;
        end
        chk("over ball_pos", 32'(ball_pos), 32'(160));
        chk("over gameover", 32'(gameover), 32'(1));
`ifdef BOUNCE_COMBO_EN
        chk("over score", 32'(score), 32'(3));
`else
        chk("over score", 32'(score), 32'(2));
`endif

        cnt0 = done_cnt;
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("over_step done_cnt", 32'(done_cnt), 32'(cnt0));
        chk("over_step ball_pos", 32'(ball_pos), 32'(160));
        chk("over_step busy",     32'(busy),     32'(0));

        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("restart ball_pos",    32'(ball_pos),    32'(0));
        chk("restart prev_ball",   32'(prev_ball),   32'(0));
        chk("restart score",       32'(score),       32'(0));
        chk("restart gameover",    32'(gameover),    32'(0));
        chk("restart plat_colors", 32'(plat_colors), 32'(m_pcol));
        m_ball   = 8'd0;
        m_prev   = 8'd0;
        m_score  = 16'd0;
        m_up     = 0;
        m_over   = 1'b0;
        m_streak = 0;

        // Step held across CHECK and MOVE must produce a single frame
        cnt0 = done_cnt;
        @(negedge clk);
        keys     = 4'hF;
        plat_pos = {N{8'd200}};
        model_step(4'hF, 1'b0, "held_step");
        step = 1'b1;
        @(posedge clk);
        #1;
        chk("held_step busy", 32'(busy), 32'(1));
        repeat (3) @(negedge clk);
        step = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("held_step done_cnt", 32'(done_cnt), 32'(cnt0 + 1));

        // Reset asserted while the frame is in CHECK
        cnt0 = done_cnt;
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        chk("mid_reset busy", 32'(busy), 32'(1));
        resetn = 1'b0;
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("mid_reset done_cnt",    32'(done_cnt),    32'(cnt0));
        chk("mid_reset ball_pos",    32'(ball_pos),    32'(0));
        chk("mid_reset score",       32'(score),       32'(0));
        chk("mid_reset plat_colors", 32'(plat_colors), 32'h8D1);
        chk("mid_reset ball_color",  32'(ball_color),  32'(1));
        chk("mid_reset busy",        32'(busy),        32'(0));
        chk("sb_empty", 32'(sb_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
